sha256_msg_schedule: RTL

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_msg_schedule.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message schedule generator. Loads sixteen 32-bit
//               message words M[0..15] into a 16-entry sliding window, then
//               emits ROUNDS schedule words W[0..ROUNDS-1] over a
//               valid/ready stream. Each accepted output shifts the window
//               down one slot and appends the next recurrence term.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROUNDS      schedule words emitted per block (legal range 16..64)
// Ports
//   clk         sole clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   in_valid    upstream message word present
//   in_ready    block accepts a message word this cycle
//   in_data     message word M[i], big-endian word order
//   w_valid     schedule word W[t] present on w_data
//   w_ready     downstream stage accepts W[t]
//   w_data      schedule word W[t]
//   w_index     round index t of w_data
//   block_done  one-cycle pulse after W[ROUNDS-1] is accepted
//   sched_err   (only with SHA256_SCHED_ERR_EN) sticky flag, set when
//               in_valid is seen while the block is emitting
// Configuration
//   SHA256_SCHED_ERR_EN  define to add the sched_err output and its logic
// ============================================================================

module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        block_done
`ifdef SHA256_SCHED_ERR_EN
  ,
  output logic        sched_err
`endif
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);
  localparam logic [3:0] LAST_LOAD = 4'd15;

  state_t      state;
  logic [3:0]  count;
  logic [5:0]  t;
  logic [31:0] win [16];   // win[0] is the oldest word and drives w_data
  logic        valid_q;
  logic        done_q;

  // Small sigma functions of the schedule recurrence (rotates are fixed
  // rewirings, so these reduce to XOR trees).
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next window entry. Relative to the word leaving at win[0] (W[t]), the
  // taps win[1], win[9], win[14] are W[t+1], W[t+9], W[t+14], which gives
  // W[t+16] by the standard recurrence.
  logic [31:0] w_next;
  assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  // in_ready is gated by reset directly so it reads 0 during every cycle in
  // which reset is asserted, including the first one, and rises in the
  // first cycle after release.
  assign in_ready   = (state == LOAD) && !reset;
  assign w_valid    = valid_q;
  assign w_data     = win[0];
  assign w_index    = t;
  assign block_done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      count   <= 4'd0;
      t       <= 6'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= 32'd0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        LOAD: begin
          // in_ready is 1 throughout LOAD outside reset.
          if (in_valid) begin
            win[count] <= in_data;
            if (count == LAST_LOAD) begin
              state   <= EMIT;
              count   <= 4'd0;
              t       <= 6'd0;
              valid_q <= 1'b1;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        EMIT: begin
          // in_valid is ignored here; without w_ready everything holds.
          if (w_ready) begin
            for (int i = 0; i < 15; i++) begin
              win[i] <= win[i+1];
            end
            win[15] <= w_next;
            if (t == LAST_T) begin
              state   <= LOAD;
              t       <= 6'd0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: begin
          state   <= LOAD;
          count   <= 4'd0;
          t       <= 6'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA256_SCHED_ERR_EN
  // Sticky protocol-violation flag: an upstream word offered while the
  // block cannot take it. Only reset clears it.
  logic err_q;
  assign sched_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_valid && (state == EMIT)) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
